// File: rtl/regfile_param.sv
// Parametrised register file: two combinational read ports, one write port,
// optional hardwired zero entry, optional same-cycle write forwarding.
module regfile_param #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 5,
  parameter bit ZERO_REG  = 1'b1,
  parameter bit BYPASS    = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wrenable,
  input  logic [ADDR_BITS-1:0] write_addr,
  input  logic [WIDTH-1:0]     write_data,
  input  logic [ADDR_BITS-1:0] read_addr1,
  input  logic [ADDR_BITS-1:0] read_addr2,
  output logic [WIDTH-1:0]     read_data1,
  output logic [WIDTH-1:0]     read_data2
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [DEPTH-1:0][WIDTH-1:0] mem;

  // Each entry is its own register so a hardwired zero entry costs no flops.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    if (ZERO_REG && (i == 0)) begin : g_zero
      assign mem[i] = '0;
    end else begin : g_reg
      logic [WIDTH-1:0] q;
      always_ff @(posedge clk) begin
        if (reset) begin
          q <= '0;
        end else if (wrenable && (write_addr == ADDR_BITS'(i))) begin
          q <= write_data;
        end
      end
      assign mem[i] = q;
    end
  end

  // Zero entry wins over forwarding; forwarding is off while reset is high.
  function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_BITS-1:0] addr);
    logic [WIDTH-1:0] data;
    data = mem[addr];
    if (ZERO_REG && (addr == '0)) begin
      data = '0;
    end else if (BYPASS && !reset && wrenable && (write_addr == addr)) begin
      data = write_data;
    end
    return data;
  endfunction

  always_comb begin
    read_data1 = read_port(read_addr1);
    read_data2 = read_port(read_addr2);
  end

endmodule
